// File: rtl/riscv_loader_pkg.sv
// Shared types and header field layout for the instruction loader.
// Load command: header (opcode + base address), byte count, packed data.
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam logic [7:0] LOAD_OPCODE = 8'hA5;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int ADDR_MSB = 23;

endpackage

// File: rtl/riscv_instr_loader.sv
// Unpacks a vld/ack word stream into byte writes for the core's
// instruction memory, holding the core in reset while loading.
module riscv_instr_loader #(
  parameter int         PAYLOAD_BITS = 32,
  parameter int         RV_ADDR_BITS = 24,
  parameter logic [7:0] LOAD_OPCODE  = riscv_loader_pkg::LOAD_OPCODE
) (
  input  logic                    clk_user,
  input  logic                    resetn,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [RV_ADDR_BITS-1:0] riscv_addr,
  output logic [7:0]              riscv_dout,
  output logic                    instr_wr_en_out,
  output logic                    core_hold,
  output logic                    load_done,
  output logic                    err_hdr
);

  import riscv_loader_pkg::*;

  state_t st, nxt;

  logic [RV_ADDR_BITS-1:0] cur_addr;
  logic [RV_ADDR_BITS-1:0] remaining;
  logic [PAYLOAD_BITS-1:0] word;
  logic [1:0]              byte_idx;

  logic xfer;
  logic opc_ok;
  logic cnt_zero;

  assign ack_out  = (st == IDLE) || (st == COUNT) || (st == DATA);
  assign xfer     = vld_in && ack_out;
  assign opc_ok   = (din[OPC_MSB:OPC_LSB] == LOAD_OPCODE);
  assign cnt_zero = (din[ADDR_MSB:0] == '0);

  // All outputs derive from registers only, never from din.
  assign instr_wr_en_out = (st == WRITE);
  assign load_done       = (st == DONE);
  assign riscv_addr      = cur_addr;
  assign riscv_dout      = word[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk_user or negedge resetn) begin
    if (!resetn) st <= IDLE;
    else         st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  if (xfer && opc_ok) nxt = COUNT;
      COUNT: if (xfer) nxt = cnt_zero ? DONE : DATA;
      DATA:  if (xfer) nxt = WRITE;
      WRITE: begin
        if (remaining == RV_ADDR_BITS'(1)) nxt = DONE;
        else if (byte_idx == 2'd3)         nxt = DATA;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_user or negedge resetn) begin
    if (!resetn) begin
      cur_addr  <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
      core_hold <= 1'b0;
      err_hdr   <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (xfer && opc_ok) begin
            cur_addr  <= din[ADDR_MSB:0];
            err_hdr   <= 1'b0;
            core_hold <= 1'b1;
          end else if (xfer) begin
            err_hdr <= 1'b1;
          end
        end
        COUNT: if (xfer) remaining <= din[ADDR_MSB:0];
        DATA: begin
          if (xfer) begin
            word     <= din;
            byte_idx <= '0;
          end
        end
        WRITE: begin
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 1'b1;
          byte_idx  <= byte_idx + 2'd1;
        end
        DONE:    core_hold <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Directed bench for riscv_instr_loader: basic, partial, zero/bad
// header, address wrap with stall, and reset mid-load.
module tb_riscv_instr_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;
  logic [23:0] riscv_addr;
  logic [7:0]  riscv_dout;
  logic        wr_en;
  logic        core_hold;
  logic        load_done;
  logic        err_hdr;

  int n_chk  = 0;
  int n_fail = 0;

  int          nw     = 0;
  int          ndone  = 0;
  int          nhold  = 0;
  int          nack0  = 0;
  logic [23:0] wa [64];
  logic [7:0]  wd [64];

  riscv_instr_loader dut (
    .clk_user        (clk),
    .resetn          (rst_n),
    .din             (din),
    .vld_in          (vld_in),
    .ack_out         (ack_out),
    .riscv_addr      (riscv_addr),
    .riscv_dout      (riscv_dout),
    .instr_wr_en_out (wr_en),
    .core_hold       (core_hold),
    .load_done       (load_done),
    .err_hdr         (err_hdr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (nw < 64) begin
        wa[nw] = riscv_addr;
        wd[nw] = riscv_dout;
      end
      nw++;
    end
    if (load_done) ndone++;
    if (core_hold) nhold++;
    if (!ack_out)  nack0++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    din    = w;
    vld_in = 1'b1;
    @(negedge clk);
    while (!ack_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ack_out) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    vld_in = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (ndone <= base && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ndone <= base) check("done_timeout", 32'd0, 32'd1);
    cyc(2);
  endtask

  task automatic check_writes(input string tag, input int base,
                              input int cnt, input logic [23:0] a0,
                              input logic [7:0] d [8]);
    logic [23:0] a;
    check({tag, "_nwr"}, nw - base, cnt);
    a = a0;
    for (int i = 0; i < cnt; i++) begin
      if (base + i < 64) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(wa[base+i]), 32'(a));
        check($sformatf("%s_data%0d", tag, i), 32'(wd[base+i]), 32'(d[i]));
      end
      a = a + 24'd1;
    end
  endtask

  int          bw, bd, bh, ba;
  logic [7:0]  exp_d [8];

  initial begin
    rst_n  = 1'b0;
    vld_in = 1'b0;
    din    = '0;
    #1;
    check("rst_ack",  32'(ack_out),    32'd1);
    check("rst_wr",   32'(wr_en),      32'd0);
    check("rst_addr", 32'(riscv_addr), 32'd0);
    check("rst_dout", 32'(riscv_dout), 32'd0);
    check("rst_hold", 32'(core_hold),  32'd0);
    check("rst_done", 32'(load_done),  32'd0);
    check("rst_err",  32'(err_hdr),    32'd0);
    #21;
    rst_n = 1'b1;
    cyc(2);

    // Basic load, vld held high
    bw = nw; bd = ndone; bh = nhold; ba = nack0;
    send(32'hA500_0100);
    send(32'h0000_0008);
    send(32'h4433_2211);
    send(32'h8877_6655);
    wait_done(bd);
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_writes("basic", bw, 8, 24'h000100, exp_d);
    check("basic_done",  ndone - bd, 1);
    check("basic_hold",  nhold - bh, 12);
    check("basic_ack0",  nack0 - ba, 9);
    check("basic_hold_end", 32'(core_hold), 32'd0);

    // Partial final word
    bw = nw; bd = ndone;
    send(32'hA500_0010);
    send(32'h0000_0006);
    send(32'hDDCC_BBAA);
    send(32'hFFFF_EEEE);
    wait_done(bd);
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hEE, 8'h00, 8'h00};
    check_writes("partial", bw, 6, 24'h000010, exp_d);
    check("partial_done", ndone - bd, 1);

    // Bad header, then zero-count load
    bw = nw; bd = ndone;
    send(32'h1234_5678);
    cyc(1);
    check("bad_err",  32'(err_hdr),   32'd1);
    check("bad_hold", 32'(core_hold), 32'd0);
    send(32'hA500_0000);
    check("zero_err_clr", 32'(err_hdr),   32'd0);
    check("zero_hold",    32'(core_hold), 32'd1);
    send(32'h0000_0000);
    wait_done(bd);
    check("zero_done", ndone - bd, 1);
    check("zero_nwr",  nw - bw, 0);

    // Address wrap with a 3-cycle stall before data
    bw = nw; bd = ndone;
    send(32'hA5FF_FFFE);
    send(32'hFF00_0004);
    din = 32'hDEAD_BEEF;
    cyc(3);
    check("stall_nwr",  nw - bw, 0);
    check("stall_hold", 32'(core_hold), 32'd1);
    check("stall_ack",  32'(ack_out),   32'd1);
    send(32'h0403_0201);
    wait_done(bd);
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    check_writes("wrap", bw, 4, 24'hFFFFFE, exp_d);

    // Reset after the second byte of a 16-byte load
    bw = nw; bd = ndone;
    send(32'hA500_0200);
    send(32'h0000_0010);
    send(32'h0D0C_0B0A);
    for (int i = 0; i < 20 && (nw - bw) < 2; i++) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_nwr",  nw - bw, 2);
    check("abort_wr",   32'(wr_en),      32'd0);
    check("abort_addr", 32'(riscv_addr), 32'd0);
    check("abort_dout", 32'(riscv_dout), 32'd0);
    check("abort_hold", 32'(core_hold),  32'd0);
    check("abort_done", 32'(load_done),  32'd0);
    check("abort_err",  32'(err_hdr),    32'd0);
    check("abort_ack",  32'(ack_out),    32'd1);
    #20;
    rst_n = 1'b1;
    cyc(1);
    check("rel_ack", 32'(ack_out), 32'd1);
    bw = nw; bd = ndone;
    send(32'hA500_0300);
    send(32'h0000_0004);
    send(32'hCAFE_BABE);
    wait_done(bd);
    exp_d = '{8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00};
    check_writes("fresh", bw, 4, 24'h000300, exp_d);
    check("fresh_done", ndone - bd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_instr_loader.md
Name: riscv_instr_loader

Overview:
- Sits between one leaf_interface user output port and the picorv32_wrapper instruction-config port.
- Consumes a 32-bit vld/ack word stream carrying a load command: a header, a byte count, then packed data words.
- Unpacks the data into one byte write per cycle on riscv_addr / riscv_dout / instr_wr_en_out.
- Holds the core in reset while a load is in progress.

Parameters:
- PAYLOAD_BITS, 32, stream word width; must be 32.
- RV_ADDR_BITS, 24, width of riscv_addr and of the byte counter.
- LOAD_OPCODE, 8'hA5, required value of header bits [31:24].

Ports:
- clk_user  in  1  user clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- din  in  32  stream word from leaf_interface (dout_leaf_interface2user_N).
- vld_in  in  1  din valid.
- ack_out  out  1  ready to upstream; a word transfers when vld_in && ack_out.
- riscv_addr  out  24  byte address of the current write.
- riscv_dout  out  8  byte data of the current write.
- instr_wr_en_out  out  1  byte write strobe, one byte per asserted cycle.
- core_hold  out  1  high from header accept through DONE; the top level ANDs its inverse into the core resetn.
- load_done  out  1  one-cycle pulse when a load completes.
- err_hdr  out  1  sticky flag for a bad header; cleared by the next valid header.

Behaviour:
- Reset (async assert, sync release): state IDLE; ack_out=1; riscv_addr, riscv_dout, instr_wr_en_out, core_hold, load_done, err_hdr = 0; internal counters = 0.
- States: IDLE, COUNT, DATA, WRITE, DONE.
- ack_out = 1 in IDLE, COUNT and DATA; 0 in WRITE and DONE.
- IDLE:
  - On transfer with din[31:24]==LOAD_OPCODE: base_addr<=din[23:0]; err_hdr<=0; core_hold<=1; go to COUNT.
  - On transfer with any other opcode: word discarded; err_hdr<=1; stay IDLE.
- COUNT:
  - On transfer: remaining<=din[23:0], with bits [31:24] ignored.
  - If din[23:0]==0, go to DONE; otherwise go to DATA.
- DATA:
  - On transfer: latch the word; byte_idx<=0; go to WRITE.
- WRITE: each cycle emits one byte.
  - instr_wr_en_out=1; riscv_addr=cur_addr; riscv_dout=word[8*byte_idx +: 8]. Bytes are little-endian, byte 0 first.
  - Then cur_addr increments, wrapping modulo 2^24; remaining decrements; byte_idx increments.
  - Exit when remaining reaches 0 (go to DONE) or byte_idx reaches 3 (go to DATA).
  - Unused bytes of the final partial word are dropped.
- DONE: one cycle; load_done=1; core_hold<=0 on exit; go to IDLE.
- Outputs are registered. A word accepted at edge t produces its byte 0 write in cycle t+1; bytes occupy cycles t+1..t+4.
- ack_out returns to 1 in cycle t+5, so full throughput is 5 cycles per word.
- Address wrap: base+count past 2^24-1 wraps to 0. No error is raised.
- vld_in low in COUNT or DATA: hold state indefinitely; core_hold stays 1.
- Reset mid-load: immediate abort; all outputs return to reset values; the partial image is left in memory. The next load starts from IDLE.
- din is ignored whenever ack_out=0.
- instr_wr_en_out is never high outside WRITE.

Decomposition:
- Shared package riscv_loader_pkg:
  - state enum (IDLE, COUNT, DATA, WRITE, DONE)
  - LOAD_OPCODE
  - header field positions (OPC_MSB=31, OPC_LSB=24, ADDR_MSB=23)
- A single module. The byte unpacker is 10-20 lines and does not justify its own sub-module.

Test Plan:
- Basic load: stream A5000100, 00000008, 44332211, 88776655 with vld held high.
  - Required: 8 writes at addr 0x100..0x107 with data 11,22,33,44,55,66,77,88.
  - Required: one load_done pulse; core_hold high from cycle after header through DONE; ack_out low 4 cycles per data word.
- Partial word: header A5000010, count 00000006, words DDCCBBAA, FFFFEEEE.
  - Required: 6 writes, AA BB CC DD EE EE at 0x10..0x15; FF bytes never written.
- Zero count and bad header:
  - Bad header 12345678 -> err_hdr=1, no writes, core_hold stays 0.
  - Then A5000000, 00000000 -> err_hdr clears, load_done pulses, no writes.
- Wrap and stall:
  - Header A5FFFFFE, count 4, word 04030201, with vld_in deasserted 3 cycles before the data word.
  - Required: writes 01@FFFFFE, 02@FFFFFF, 03@000000, 04@000001; no writes during the stall.
- Reset mid-load:
  - Assert resetn=0 after the second byte write of a 16-byte load.
  - Required: all outputs 0 asynchronously. After release, ack_out=1 and a fresh 4-byte load completes correctly.
